// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-look-ahead adder.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NIB_W = 4;

   // Nibble counter width for a given operand width (WIDTH >= 8, so at least 1).
   function automatic int cnt_width(input int width);
      return $clog2(width / NIB_W);
   endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-look-ahead slice; c3 is the carry into bit 3,
// exported so the caller can form signed overflow as c3 ^ co.
module cla_slice4
   import cla_seq_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             ci,
   output logic [NIB_W-1:0] s,
   output logic             co,
   output logic             c3
);

   logic [NIB_W-1:0] w_g;
   logic [NIB_W-1:0] w_p;
   logic             w_c1;
   logic             w_c2;

   assign w_g = a & b;
   assign w_p = a ^ b;

   assign w_c1 = w_g[0] | (w_p[0] & ci);
   assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
   assign c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & ci);
   assign co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

   assign s = w_p ^ {c3, w_c2, w_c1, ci};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder reusing one 4-bit CLA slice, one nibble per clock, LSB first.
// Define CLA_SEQ_SUB_EN to add the `sub` port (A - B via inverted B and forced carry-in).
module cla_seq_adder
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high; valid never depends combinationally on ready, and once out_valid rises the
   // result holds until the transfer.

   localparam int NIB   = WIDTH / NIB_W;
   localparam int CNT_W = cnt_width(WIDTH);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum_sh;
   logic               r_carry;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_accept;
   logic               w_last;
   logic               w_init_c;
   logic [NIB_W-1:0]   w_b_nib;
   logic [NIB_W-1:0]   w_s;
   logic               w_co;
   logic               w_c3;

`ifdef CLA_SEQ_SUB_EN
   logic               r_sub;

   assign w_b_nib  = r_b_sh[NIB_W-1:0] ^ {NIB_W{r_sub}};
   assign w_init_c = sub | cin;
`else
   assign w_b_nib  = r_b_sh[NIB_W-1:0];
   assign w_init_c = cin;
`endif

   assign in_ready  = (r_state == ST_IDLE) && !rst;
   assign w_accept  = in_valid && in_ready;
   assign w_last    = (r_cnt == CNT_W'(NIB - 1));
   assign out_valid = (r_state == ST_DONE);
   assign sum       = r_sum_sh;
   assign cout      = r_carry;
   assign ovf       = r_ovf;
   assign dbg_state = r_state;

   cla_slice4 u_slice (
      .a  (r_a_sh[NIB_W-1:0]),
      .b  (w_b_nib),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co),
      .c3 (w_c3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
`ifdef CLA_SEQ_SUB_EN
         r_sub    <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_carry <= w_init_c;
                  r_cnt   <= '0;
`ifdef CLA_SEQ_SUB_EN
                  r_sub   <= sub;
`endif
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // After NIB shifts the result nibbles land in natural bit order.
               r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:NIB_W]};
               r_a_sh   <= r_a_sh >> NIB_W;
               r_b_sh   <= r_b_sh >> NIB_W;
               r_carry  <= w_co;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_ovf   <= w_c3 ^ w_co;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed + random bench for cla_seq_adder with an expected-result scoreboard queue.
module tb_cla_seq_adder;
  import cla_seq_pkg::*;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  logic [W+1:0] exp_q[$];
  int n_checks = 0;
  int n_bad    = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // Returns {ovf, cout, sum}; overflow from operand/result sign bits.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    logic         v;
    bb   = msub ? ~mb : mb;
    c    = msub ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c};
    v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tcin, input logic tsub);
    int waitc;
    a = ta; b = tb_v; cin = tcin; sub = tsub;
    in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_wait", (waitc < 50) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    exp_q.push_back(model(ta, tb_v, tcin, tsub));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall first.
  task automatic receive(input string tag, input int stall);
    int           lat;
    logic [W+1:0] e;
    logic [W-1:0] held;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    check({tag, "_latency"}, lat, NIB);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_bad++;
      $error("FAIL %s_scoreboard: observed=result expected=empty queue", tag);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(e[W]));
    check({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
    held = sum;
    if (stall > 0) begin
      in_valid = 1'b1;
      a = W'($urandom_range(0, 65535));
      b = W'($urandom_range(0, 65535));
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_stall_sum"}, 32'(sum), 32'(held));
        check({tag, "_stall_inrdy"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_inrdy"}, 32'(in_ready), 32'd1);
    if (stall > 0) begin
      // The operands offered during the stall must not have started an operation.
      for (int i = 0; i < NIB + 2; i++) begin
        @(negedge clk);
        check({tag, "_ignored_state"}, 32'(dbg_state), 32'(ST_IDLE));
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_state", 32'(dbg_state), 32'(ST_IDLE));

    send(16'h1234, 16'h4321, 1'b0, 1'b0);  receive("basic", 0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);  receive("ripple", 0);
    send(16'h0000, 16'h0000, 1'b1, 1'b0);  receive("cin_only", 0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);  receive("ovf", 0);
    send(16'h1111, 16'h2222, 1'b0, 1'b0);  receive("bp", 5);

    // Reset in the second RUN cycle drops the operation.
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_inrdy", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NIB + 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    send(16'h0001, 16'h0002, 1'b0, 1'b0);  receive("after_rst", 0);

`ifdef CLA_SEQ_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);  receive("sub_borrow", 0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);  receive("sub_ovf", 0);
    send(16'h0009, 16'h0003, 1'b0, 1'b1);  receive("sub_plain", 0);
`endif

    for (int i = 0; i < 8; i++) begin
      logic rs;
`ifdef CLA_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      send(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)), rs);
      receive("rand", $urandom_range(0, 2));
    end

    check("q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle N-bit adder that reuses a single 4-bit carry-look-ahead slice, one nibble per clock, least significant first. It accepts an operand pair over a valid/ready handshake, ripples the carry through a register between nibbles, and returns the full sum, carry-out and signed overflow over a second valid/ready handshake. It sits between operand-producing logic and result consumers where area matters more than single-cycle latency.

## Interface
- `WIDTH`, 16: operand width in bits; must be a multiple of 4 and ≥ 8.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand pair on `a`, `b` and `cin` is valid.
- `in_ready` output 1: block can accept operands; high only in IDLE, low while `rst` is high.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry into nibble 0.
- `sub` input 1: subtract select; present only with `CLA_SEQ_SUB_EN`.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: result.
- `cout` output 1: carry out of the MSB nibble.
- `ovf` output 1: two's-complement overflow, equal to the carry into bit WIDTH-1 XOR `cout`.

## Operation
- Define NIB = WIDTH/4. The state machine has three states: IDLE, RUN and DONE.
- **IDLE:** `in_ready` = 1. On `in_valid && in_ready`:
  - latch `a` and `b` into shift registers;
  - set the carry register to `cin`;
  - clear the nibble counter;
  - go to RUN.
- **RUN:** each cycle the slice adds `a_sh[3:0]`, `b_sh[3:0]` and the carry register.
  - The slice sum shifts into `sum_sh[WIDTH-1:WIDTH-4]`, and `sum_sh` shifts right by 4.
  - `a_sh` and `b_sh` shift right by 4.
  - The carry register takes the slice carry-out.
  - The counter increments. When the counter reaches NIB-1, the state goes to DONE in the same edge.
  - On that final nibble, `ovf` is captured as (slice carry into bit 3) XOR (slice carry-out).
- **DONE:**
  - `out_valid` = 1.
  - `sum`, `cout` and `ovf` are stable and do not change until the handshake.
  - On `out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. Only one operation is in flight at a time.
- `sum`, `cout` and `ovf` hold their last result in IDLE. Their value is only meaningful while `out_valid` is high.
- **Reset at any time, including mid-RUN and in DONE:**
  - state goes to IDLE;
  - all registers clear;
  - the in-flight operation is dropped, and no `out_valid` pulse is produced for it.
- **Reset values:** `out_valid` 0, `sum` 0, `cout` 0, `ovf` 0. `in_ready` is 0 while `rst` is high and 1 from the first cycle after release.

## Timing
- The accept edge is E0. Nibble k is computed on edge E(k+1).
- `out_valid` rises after edge E(NIB), so latency is NIB cycles (4 for WIDTH=16).
- With `out_ready` held high, the result transfers at E(NIB+1) and `in_ready` is high from E(NIB+1).
- Maximum throughput is one operation per NIB+2 cycles.
- A back-to-back `in_valid` presented in the cycle the result transfers is not accepted until the following cycle.
- There are no combinational paths from inputs to outputs, except `rst` to `in_ready`.

## Configuration
- **`CLA_SEQ_SUB_EN` defined:**
  - the `sub` port exists and is latched with the operands on accept;
  - when `sub` = 1, every B nibble is inverted before the slice and the initial carry is forced to 1, so `cin` is ignored;
  - `cout` = 1 means no borrow, and `ovf` is the signed overflow of A−B.
- **`CLA_SEQ_SUB_EN` undefined:** no `sub` port, addition only, and no inverter logic is present.

## Structure
- A shared package `cla_seq_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the constant `NIB_W = 4`;
  - a function returning the counter width, `$clog2(WIDTH/4)`.
- One sub-module, `cla_slice4`: a combinational 4-bit carry-look-ahead slice.
  - Inputs: `a[3:0]`, `b[3:0]`, `ci`.
  - Outputs: `s[3:0]`, `co`, and `c3`, the carry into bit 3, which is used for `ovf`.
  - It is instantiated exactly once.

## Test plan
- **Basic add:** WIDTH=16, a=0x1234, b=0x4321, cin=0 → `out_valid` exactly 4 cycles after accept, `sum`=0x5555, `cout`=0, `ovf`=0.
- **Carry ripple:** a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1, `ovf`=0. Also a=0x0000, b=0x0000, cin=1 → `sum`=0x0001.
- **Signed overflow:** a=0x7FFF, b=0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1.
- **Backpressure:**
  - hold `out_ready`=0 for 5 cycles in DONE → `sum` stays stable, `in_ready`=0, and a new `in_valid` is ignored;
  - then raise `out_ready` → single transfer, and `in_ready`=1 on the next cycle.
- **Reset mid-operation:** assert `rst` in the 2nd RUN cycle → all outputs 0 immediately and no `out_valid`. After release, a=0x0001, b=0x0002 gives `sum`=0x0003.
- **Subtract** (`CLA_SEQ_SUB_EN`): a=0x0005, b=0x0007, sub=1 → `sum`=0xFFFE, `cout`=0. a=0x8000, b=0x0001, sub=1 → `sum`=0x7FFF, `ovf`=1.
